// File: rtl/tmds_pkg.sv
// Constants shared by the TMDS encoder and decoder: control tokens, TERC4 table,
// guard-band patterns and the alignment state type.
package tmds_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    // Index is the decoded {C1,C0} value; patterns are written q[9:0].
    localparam logic [9:0] CTRL_TOKEN [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    // Index is the TERC4 nibble.
    localparam logic [9:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    localparam logic [9:0] VGUARD_CH0 = 10'b1011001100;
    localparam logic [9:0] VGUARD_CH1 = 10'b0100110011;
    localparam logic [9:0] VGUARD_CH2 = 10'b1011001100;
    localparam logic [9:0] DGUARD     = 10'b0100110011;

    function automatic logic [9:0] vguard_for(input int channel);
        case (channel)
            1:       vguard_for = VGUARD_CH1;
            2:       vguard_for = VGUARD_CH2;
            default: vguard_for = VGUARD_CH0;
        endcase
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned TMDS symbol into every interpretation at once;
// deciding which one applies is left to the packet layer.
module tmds_symbol_decode
    import tmds_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic [9:0] q,
    output logic [7:0] data,
    output logic       ctrl_valid,
    output logic [1:0] ctrl,
    output logic       terc4_valid,
    output logic [3:0] terc4,
    output logic       vguard,
    output logic       dguard
);

    localparam logic [9:0] VGUARD_PAT = vguard_for(CHANNEL);
    localparam bit         HAS_DGUARD = (CHANNEL != 0);

    logic [7:0] qi;
    logic [7:0] d;

    always_comb begin
        qi = q[9] ? ~q[7:0] : q[7:0];
        d = '0;
        d[0] = qi[0];
        // q8 selects XOR versus XNOR chaining of the transition-minimised word.
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (qi[i] ^ qi[i-1]) : ~(qi[i] ^ qi[i-1]);
        end
        data = d;
    end

    always_comb begin
        ctrl_valid  = 1'b0;
        ctrl        = 2'b00;
        terc4_valid = 1'b0;
        terc4       = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (q == CTRL_TOKEN[k]) begin
                ctrl_valid = 1'b1;
                ctrl       = 2'(k);
            end
        end
        for (int k = 0; k < 16; k++) begin
            if (q == TERC4_CODE[k]) begin
                terc4_valid = 1'b1;
                terc4       = 4'(k);
            end
        end
    end

    assign vguard = (q == VGUARD_PAT);
    assign dguard = HAS_DGUARD & (q == DGUARD);

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: bit alignment by control-token hunting, barrel select,
// and a registered parallel decode of the aligned symbol.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CHANNEL       = 0,
    parameter int LOCK_TOKENS   = 8,
    parameter int SEARCH_WINDOW = 128,
    parameter int LOSS_WINDOW   = 1_048_576
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] tmds_raw_i,
    output logic       locked_o,
    output logic [3:0] offset_o,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       ctrl_valid_o,
    output logic [1:0] ctrl_o,
    output logic       terc4_valid_o,
    output logic [3:0] terc4_o,
    output logic       vguard_o,
    output logic       dguard_o,
    output logic       de_o
);

    localparam int RUN_W  = $clog2(LOCK_TOKENS + 1);
    localparam int WIN_W  = (SEARCH_WINDOW > 2) ? $clog2(SEARCH_WINDOW) : 1;
    localparam int LOSS_W = (LOSS_WINDOW > 2) ? $clog2(LOSS_WINDOW) : 1;

    localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_TOKENS);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOW - 1);

    align_state_t      state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d, run_inc;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic [3:0]        offset_q, offset_d, offset_inc;
    logic              lock_hit;

    logic [9:0]  raw_p0;
    logic [18:0] window;
    logic [9:0]  sym_sel;
    logic [9:0]  sym_p1;

    logic [7:0] dec_data;
    logic       dec_ctrl_valid;
    logic [1:0] dec_ctrl;
    logic       dec_terc4_valid;
    logic [3:0] dec_terc4;
    logic       dec_vguard;
    logic       dec_dguard;

    logic [7:0] data_p2;
    logic       ctrl_valid_p2;
    logic [1:0] ctrl_p2;
    logic       terc4_valid_p2;
    logic [3:0] terc4_p2;
    logic       vguard_p2;
    logic       dguard_p2;
    logic       de_p2;
    logic       vld_p2;

    // Stage 1: window of previous + current word, barrel select at the current offset.
    // The top bit of the current word can never fall inside a 10-bit slice at offset <= 9.
    assign window = {tmds_raw_i[8:0], raw_p0};

    always_comb begin
        sym_sel = window[9:0];
        for (int k = 1; k < 10; k++) begin
            if (offset_q == 4'(k)) begin
                sym_sel = window[k +: 10];
            end
        end
    end

    tmds_symbol_decode #(
        .CHANNEL (CHANNEL)
    ) u_decode (
        .q           (sym_p1),
        .data        (dec_data),
        .ctrl_valid  (dec_ctrl_valid),
        .ctrl        (dec_ctrl),
        .terc4_valid (dec_terc4_valid),
        .terc4       (dec_terc4),
        .vguard      (dec_vguard),
        .dguard      (dec_dguard)
    );

    assign offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    assign run_inc    = !dec_ctrl_valid ? '0 :
                        (run_q == RUN_LOCK) ? RUN_LOCK : run_q + RUN_W'(1);
    assign lock_hit   = (run_inc == RUN_LOCK);

    always_comb begin
        state_d  = state_q;
        run_d    = run_inc;
        win_d    = win_q;
        loss_d   = loss_q;
        offset_d = offset_q;
        case (state_q)
            SEARCH: begin
                loss_d = '0;
                // A lock run completing on the last window symbol keeps this offset.
                if (lock_hit) begin
                    state_d = LOCKED;
                    win_d   = '0;
                end else if (win_q == WIN_LAST) begin
                    offset_d = offset_inc;
                    win_d    = '0;
                    run_d    = '0;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            LOCKED: begin
                win_d = '0;
                if (lock_hit) begin
                    loss_d = '0;
                end else if (loss_q == LOSS_LAST) begin
                    state_d  = SEARCH;
                    offset_d = offset_inc;
                    loss_d   = '0;
                    run_d    = '0;
                end else begin
                    loss_d = loss_q + LOSS_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q  <= SEARCH;
            run_q    <= '0;
            win_q    <= '0;
            loss_q   <= '0;
            offset_q <= '0;
            raw_p0   <= '0;
            sym_p1   <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            win_q    <= win_d;
            loss_q   <= loss_d;
            offset_q <= offset_d;
            raw_p0   <= tmds_raw_i;
            sym_p1   <= sym_sel;
        end
    end

    // Stage 2: register every decode of the stage-1 symbol.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            data_p2        <= '0;
            ctrl_valid_p2  <= 1'b0;
            ctrl_p2        <= '0;
            terc4_valid_p2 <= 1'b0;
            terc4_p2       <= '0;
            vguard_p2      <= 1'b0;
            dguard_p2      <= 1'b0;
            de_p2          <= 1'b1;
            vld_p2         <= 1'b0;
        end else begin
            data_p2        <= dec_data;
            ctrl_valid_p2  <= dec_ctrl_valid;
            ctrl_p2        <= dec_ctrl;
            terc4_valid_p2 <= dec_terc4_valid;
            terc4_p2       <= dec_terc4;
            vguard_p2      <= dec_vguard;
            dguard_p2      <= dec_dguard;
            de_p2          <= ~dec_ctrl_valid;
            vld_p2         <= (state_q == LOCKED);
        end
    end

    assign locked_o      = (state_q == LOCKED);
    assign offset_o      = offset_q;
    assign valid_o       = vld_p2;
    assign data_o        = data_p2;
    assign ctrl_valid_o  = ctrl_valid_p2;
    assign ctrl_o        = ctrl_p2;
    assign terc4_valid_o = terc4_valid_p2;
    assign terc4_o       = terc4_p2;
    assign vguard_o      = vguard_p2;
    assign dguard_o      = dguard_p2;
    assign de_o          = de_p2;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench: channel-0 and channel-1 decoders fed the same raw stream.
module tb_tmds_channel_decoder;

    logic       clk_pixel = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] tmds_raw_i = '0;

    logic       locked_a, valid_a, ctrl_valid_a, terc4_valid_a, vguard_a, dguard_a, de_a;
    logic [3:0] offset_a, terc4_a;
    logic [7:0] data_a;
    logic [1:0] ctrl_a;
    logic       locked_b, valid_b, ctrl_valid_b, terc4_valid_b, vguard_b, dguard_b, de_b;
    logic [3:0] offset_b, terc4_b;
    logic [7:0] data_b;
    logic [1:0] ctrl_b;

    logic [24:0] obs_a, obs_b;
    assign obs_a = {locked_a, offset_a, valid_a, data_a, ctrl_valid_a, ctrl_a,
                    terc4_valid_a, terc4_a, vguard_a, dguard_a, de_a};
    assign obs_b = {locked_b, offset_b, valid_b, data_b, ctrl_valid_b, ctrl_b,
                    terc4_valid_b, terc4_b, vguard_b, dguard_b, de_b};

    localparam logic [9:0] T0   = 10'b1101010100;
    localparam logic [9:0] T1   = 10'b0010101011;
    localparam logic [9:0] T2   = 10'b0101010100;
    localparam logic [9:0] T3   = 10'b1010101011;
    localparam logic [9:0] VID0 = 10'b0100000000;

    int passed = 0;
    int total  = 0;

    tmds_channel_decoder #(.CHANNEL(0), .LOCK_TOKENS(8), .SEARCH_WINDOW(128), .LOSS_WINDOW(1024)) dut0 (
        .clk_pixel(clk_pixel), .reset(reset), .tmds_raw_i(tmds_raw_i),
        .locked_o(locked_a), .offset_o(offset_a), .valid_o(valid_a), .data_o(data_a),
        .ctrl_valid_o(ctrl_valid_a), .ctrl_o(ctrl_a), .terc4_valid_o(terc4_valid_a),
        .terc4_o(terc4_a), .vguard_o(vguard_a), .dguard_o(dguard_a), .de_o(de_a)
    );

    tmds_channel_decoder #(.CHANNEL(1), .LOCK_TOKENS(8), .SEARCH_WINDOW(128), .LOSS_WINDOW(1024)) dut1 (
        .clk_pixel(clk_pixel), .reset(reset), .tmds_raw_i(tmds_raw_i),
        .locked_o(locked_b), .offset_o(offset_b), .valid_o(valid_b), .data_o(data_b),
        .ctrl_valid_o(ctrl_valid_b), .ctrl_o(ctrl_b), .terc4_valid_o(terc4_valid_b),
        .terc4_o(terc4_b), .vguard_o(vguard_b), .dguard_o(dguard_b), .de_o(de_b)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input logic [9:0] v);
        tmds_raw_i = v;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic send3(input logic [9:0] v);
        cyc(v);
        cyc(v);
        cyc(v);
    endtask

    function automatic logic [9:0] rotl(input logic [9:0] x, input int d);
        logic [9:0] r;
        r = x;
        for (int i = 0; i < d; i++) r = {r[8:0], r[9]};
        return r;
    endfunction

    // Run an aligned-by-d token stream from reset release until lock; reports cycles and slips.
    task automatic hunt(input logic [9:0] v, input string tag, output int n, output int steps);
        logic [3:0] prev;
        int last;
        prev  = offset_a;
        last  = 0;
        n     = 0;
        steps = 0;
        while (!locked_a && n < 2000) begin
            cyc(v);
            n = n + 1;
            if (offset_a != prev) begin
                chk({tag, "_step"}, 32'(offset_a), 32'(prev + 4'd1));
                chk({tag, "_interval"}, 32'(n - last), 128);
                steps = steps + 1;
                last  = n;
                prev  = offset_a;
            end
        end
    endtask

    initial begin
        int n;
        int steps;
        logic [9:0] r1, r3, r7;
        r1 = rotl(T0, 1);
        r3 = rotl(T0, 3);
        r7 = rotl(T0, 7);

        // Reset with random input
        reset = 1'b1;
        for (int i = 0; i < 5; i++) cyc(10'($urandom));
        chk("reset_ch0", 32'(obs_a), 32'h1);
        chk("reset_ch1", 32'(obs_b), 32'h1);
        reset = 1'b0;

        // Lock at offset 0
        for (int i = 1; i <= 13; i++) begin
            cyc((i <= 10) ? T0 : VID0);
            if (i == 9) chk("lock_not_yet", 32'(locked_a), 0);
            if (i == 10) begin
                chk("lock_rise", 32'(locked_a), 1);
                chk("lock_offset0", 32'(offset_a), 0);
                chk("valid_lags", 32'(valid_a), 0);
            end
            if (i == 11) chk("valid_rise", 32'(valid_a), 1);
            if (i == 12) chk("token_ctrl00", 32'({ctrl_valid_a, ctrl_a, de_a}), 32'b1_00_0);
            if (i == 13) chk("vid_decode", 32'({data_a, de_a, valid_a}), 32'h0_03);
        end

        // Decode coverage
        send3(10'b1011111111);
        chk("data_fe", 32'({data_a, de_a}), 32'h1FD);
        send3(10'b0111111111);
        chk("data_01", 32'(data_a), 32'h01);
        send3(10'b1010011100);
        chk("terc4_0", 32'({terc4_valid_a, terc4_a, ctrl_valid_a, data_a}), 32'b1_0000_0_01011011);
        send3(10'b1011001100);
        chk("vguard_ch0", 32'({terc4_valid_a, terc4_a, vguard_a, dguard_a}), 32'b1_1000_1_0);
        chk("vguard_ch1_no", 32'({vguard_b, dguard_b}), 0);
        send3(10'b0100110011);
        chk("guard_ch1", 32'({vguard_b, dguard_b, terc4_valid_b}), 32'b110);
        chk("guard_ch0_no", 32'({vguard_a, dguard_a}), 0);
        send3(T1);
        chk("token_ctrl01", 32'({ctrl_valid_a, ctrl_a, de_a}), 32'b1_01_0);
        send3(T2);
        chk("token_ctrl10", 32'({ctrl_valid_a, ctrl_a, de_a}), 32'b1_10_0);
        send3(T3);
        chk("token_ctrl11", 32'({ctrl_valid_a, ctrl_a, de_a, valid_a}), 32'b1_11_0_1);

        // Loss of lock: 1024 stage-1 symbols after the last qualifying token
        for (int i = 0; i < 10; i++) cyc(T0);
        n = 0;
        do begin
            cyc(VID0);
            n = n + 1;
        end while (locked_a && n < 1100);
        chk("loss_cycles", n, 1026);
        chk("loss_offset", 32'(offset_a), 1);

        // Lock run completing exactly on window expiry at offset 1
        for (int m = 1; m <= 128; m++) begin
            cyc((m <= 118) ? VID0 : r1);
            if (m == 127) chk("simul_before", 32'({locked_a, offset_a}), 32'h01);
            if (m == 128) chk("simul_lock_wins", 32'({locked_a, offset_a}), 32'h11);
        end
        send3(r1);
        chk("simul_decode", 32'({valid_a, ctrl_valid_a, ctrl_a}), 32'b1_1_00);

        // Slip acquisition at offset 7
        reset = 1'b1;
        cyc(r7);
        cyc(r7);
        reset = 1'b0;
        hunt(r7, "slip7", n, steps);
        chk("slip7_steps", steps, 7);
        chk("slip7_lock_cycle", n, 905);
        chk("slip7_locked", 32'({locked_a, offset_a}), 32'h17);
        send3(r7);
        chk("slip7_ctrl", 32'({valid_a, ctrl_valid_a, ctrl_a, de_a}), 32'b1_1_00_0);

        // Reset pulse while locked at offset 3
        reset = 1'b1;
        cyc(r3);
        cyc(r3);
        reset = 1'b0;
        hunt(r3, "slip3", n, steps);
        chk("slip3_lock_cycle", n, 393);
        chk("slip3_locked", 32'({locked_a, offset_a}), 32'h13);
        for (int i = 0; i < 5; i++) cyc(r3);
        reset = 1'b1;
        cyc(r3);
        chk("midlock_reset", 32'(obs_a), 32'h1);
        reset = 1'b0;
        hunt(r3, "relock3", n, steps);
        chk("relock3_cycle", n, 393);
        chk("relock3_locked", 32'({locked_a, offset_a}), 32'h13);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side counterpart of the HDMI TMDS channel encoder. It takes one unaligned 10-bit TMDS symbol per pixel clock from a deserializer, finds symbol alignment by hunting for control-token runs, and decodes each aligned symbol in parallel into video data, control bits, TERC4 nibble and guard-band flags. It is used for HDMI loopback self-test and bench checking of the output path, with one instance per TMDS channel.

## Interface

Parameters:
- CHANNEL, 0: TMDS channel index 0..2; selects the guard-band patterns.
- LOCK_TOKENS, 8: consecutive control tokens required to declare lock (2..255).
- SEARCH_WINDOW, 128: symbols tried at one bit offset before slipping.
- LOSS_WINDOW, 1_048_576: symbols allowed in LOCKED without a qualifying control run before lock is dropped.

Ports:
- clk_pixel  in  1  pixel clock; one symbol per cycle.
- reset  in  1  synchronous, active-high.
- tmds_raw_i  in  10  unaligned symbol bits; bit 0 is received first.
- locked_o  out  1  alignment acquired.
- offset_o  out  4  current bit offset, 0..9.
- valid_o  out  1  decoded outputs are meaningful; equals locked, pipeline-aligned.
- data_o  out  8  video (8b/10b-TMDS) decode of the symbol.
- ctrl_valid_o  out  1  symbol is one of the 4 control tokens.
- ctrl_o  out  2  {C1,C0} of the control token; 0 when not a token.
- terc4_valid_o  out  1  symbol is a TERC4 code.
- terc4_o  out  4  TERC4 nibble; 0 when invalid.
- vguard_o  out  1  matches the video guard band for CHANNEL.
- dguard_o  out  1  matches the data guard band (CHANNEL 1 or 2 only; always 0 for CHANNEL 0).
- de_o  out  1  inverse of ctrl_valid_o.

## Operation

- A 20-bit window {tmds_raw_i, previous tmds_raw_i} is kept. The aligned symbol q[9:0] is window[offset+9 : offset].
- Control tokens, written as q[9:0]: 1101010100 decodes to 00, 0010101011 to 01, 0101010100 to 10, 1010101011 to 11.
- Video decode:
  - If q9 is set, invert q[7:0] first.
  - d0 = q0.
  - For i = 1..7: di = q[i]^q[i-1] when q8 = 1, and ~(q[i]^q[i-1]) when q8 = 0.
- TERC4 uses the 16-entry HDMI 1.4 table.
- Guard bands:
  - Video guard band is 1011001100 for channels 0 and 2, and 0100110011 for channel 1.
  - Data guard band is 0100110011.
- All decodes are computed every cycle with no priority. Classification belongs to the packet layer.
  - Example: 1011001100 asserts terc4_valid_o (nibble 1000) and also vguard_o.
- State machine for alignment:
  - SEARCH:
    - run_cnt counts consecutive control tokens at the current offset and clears on any non-token.
    - win_cnt counts symbols at this offset.
    - When run_cnt reaches LOCK_TOKENS, go to LOCKED.
    - When win_cnt reaches SEARCH_WINDOW-1 without lock, advance the offset (9 wraps to 0) and clear both counters.
  - LOCKED:
    - loss_cnt clears whenever run_cnt reaches LOCK_TOKENS.
    - When loss_cnt reaches LOSS_WINDOW-1, return to SEARCH, advance the offset by one, and clear all counters.
  - On a simultaneous lock event and window expiry, lock wins and the offset is unchanged.
  - run_cnt saturates at LOCK_TOKENS.
- While locked_o is 0, valid_o is 0. Decode outputs still toggle but carry no meaning.

## Timing

- Reset values: locked_o=0, offset_o=0, valid_o=0, data_o=0, ctrl_valid_o=0, ctrl_o=0, terc4_valid_o=0, terc4_o=0, vguard_o=0, dguard_o=0, de_o=1. All counters are 0 and the state is SEARCH.
- Pipeline:
  - Stage 1 registers the window and the selected symbol.
  - Stage 2 registers all decodes.
  - Latency from tmds_raw_i to decoded outputs is 2 cycles.
- locked_o rises in the cycle after the LOCK_TOKENS-th consecutive token reaches stage 1. valid_o rises 1 cycle after locked_o.
- An offset change takes effect in the next cycle. The first symbol at the new offset emerges 2 cycles later.
- Reset asserted mid-lock forces all reset values in the next cycle, and the offset restarts at 0.

## Structure

- Package tmds_pkg holds the shared constants:
  - CTRL_TOKEN[4]
  - TERC4_CODE[16]
  - VGUARD_CH0/1/2 and DGUARD
  - the alignment state enum (SEARCH, LOCKED)
- The encoder side imports the same package.
- Sub-module tmds_symbol_decode: purely combinational, maps q[9:0] to all decode fields. It is reused by the packet-layer checker.
- The top holds the window, barrel select, FSM, counters and the output registers.
- Target size is roughly 200 lines.

## Test plan

1. Reset: drive random tmds_raw_i with reset high for 5 cycles. All outputs must equal their reset values, with de_o=1.
2. Lock at offset 0: send 10 × 1101010100, then 0100000000. locked_o rises after the 8th token and stays at offset 0. The 0100000000 symbol appears 2 cycles later as data_o=0x00, de_o=1, valid_o=1.
3. Slip acquisition: send a token stream delayed by 7 bits. offset_o steps 0→7, one step per 128 symbols, then lock occurs. ctrl_o reads 00 on each token.
4. Decode coverage:
   - 1011111111 → data_o=0xFE
   - 1010011100 → terc4_valid_o=1, terc4_o=0
   - 1011001100 on CHANNEL 0 → vguard_o=1 and terc4_o=1000
   - 0100110011 on CHANNEL 1 → vguard_o=1 and dguard_o=1
5. Loss of lock: after lock, use LOSS_WINDOW=1024 and send only 0100000000. locked_o falls after 1024 symbols and offset_o becomes 1. A simultaneous lock run arriving at window expiry keeps the offset.
6. Reset mid-lock: while locked at offset 3, pulse reset for one cycle. In the next cycle locked_o=0 and offset_o=0, and re-lock follows step 3 behaviour.
